outmem_uart_streamer: RTL

- Downstream consumer of the processor's output data memory.
- After a program finishes, the block reads a software-specified number of 32-bit words from that memory through a dedicated read port.
- It serialises the low BYTES_PER_WORD bytes of each word onto an 8N1 UART line for host-side capture.
- Standalone sequencer: FSM, baud counter, bit counter, word address counter.

---
 rtl/outstream_pkg.sv | 21 ++
 rtl/baud_tick.sv | 31 +++
 rtl/outmem_uart_streamer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/outstream_pkg.sv
// rtl/outstream_pkg.sv - shared types and constants for the output-memory UART streamer
// OUTSTREAM_PARITY_EN adds the PARITY state to the sequencer enum.
package outstream_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_START,
        ST_DATA,
`ifdef OUTSTREAM_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/baud_tick.sv
// rtl/baud_tick.sv - bit-period down-counter; tick marks the last cycle of each UART bit
module baud_tick
    import outstream_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // clear realigns the bit period to a state entry
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/outmem_uart_streamer.sv
// rtl/outmem_uart_streamer.sv - reads N words from output memory and streams their low bytes over UART
// OUTSTREAM_PARITY_EN selects 8E1 framing instead of the default 8N1.
module outmem_uart_streamer
    import outstream_pkg::*;
#(
    parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
    parameter int ADDR_W         = 8,
    parameter int BYTES_PER_WORD = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              tx
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);
    localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);

    state_t          state;
    state_t          state_next;
    logic [ADDR_W:0] count_q;
    logic [31:0]     word_buf;
    logic [1:0]      byte_idx;
    logic [2:0]      bit_idx;
    logic [7:0]      cur_byte;
    logic            last_byte;
    logic            last_word;
    logic            tick;
    logic            baud_clear;

    assign cur_byte   = word_buf[{byte_idx, 3'b000} +: 8];
    assign last_byte  = (byte_idx == LAST_BYTE);
    assign last_word  = (({1'b0, mem_addr} + (ADDR_W + 1)'(1)) >= count_q);
    assign baud_clear = (state_next != state);

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .reset(reset),
        .clear(baud_clear),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = (word_count == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH: state_next = ST_LATCH;
            ST_LATCH: state_next = ST_START;
            ST_START: if (tick) state_next = ST_DATA;
`ifdef OUTSTREAM_PARITY_EN
            ST_DATA:   if (tick && bit_idx == LAST_BIT) state_next = ST_PARITY;
            ST_PARITY: if (tick) state_next = ST_STOP;
`else
            ST_DATA:   if (tick && bit_idx == LAST_BIT) state_next = ST_STOP;
`endif
            ST_STOP: begin
                if (tick) begin
                    if (!last_byte)      state_next = ST_START;
                    else if (!last_word) state_next = ST_FETCH;
                    else                 state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        busy = (state != ST_IDLE) && (state != ST_DONE);
        done = (state == ST_DONE);
        case (state)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = cur_byte[bit_idx];
`ifdef OUTSTREAM_PARITY_EN
            ST_PARITY: tx = ^cur_byte;
`endif
            default:   tx = 1'b1;
        endcase
    end

    // mem_addr only moves at word boundaries and never past the last requested word
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            word_buf <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            mem_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        count_q  <= (word_count > DEPTH_CNT) ? DEPTH_CNT : word_count;
                        mem_addr <= '0;
                    end
                end
                ST_LATCH: begin
                    word_buf <= mem_rdata;
                    byte_idx <= '0;
                    bit_idx  <= '0;
                end
                ST_DATA: begin
                    if (tick) bit_idx <= bit_idx + 3'd1;
                end
                ST_STOP: begin
                    if (tick) begin
                        if (!last_byte)      byte_idx <= byte_idx + 2'd1;
                        else if (!last_word) mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
